ws2812_frame_ctrl: RTL and testbench
====================================

# ws2812_frame_ctrl

Double-buffered 64-pixel frame controller for the WS2812 strip driver. Up to two game-logic requesters write pixel colours into a back buffer through a round-robin arbiter. The block swaps buffers at the driver's frame boundary on request, then copies the new front buffer into the back buffer. It serves the driver's pixel index with a combinational colour lookup from the front buffer.

## Interface
Parameters:
- NPIX, 64, pixels per frame; the driver index wraps from NPIX-1 to 0.
- AW, 6, pixel address width; must satisfy 2^AW ≥ NPIX.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- pixel_idx  in  AW  current pixel index from the strip driver.
- color_out  out  24  GRB colour for pixel_idx, read from the front buffer.
- req_a  in  1  requester A write request; held until acked.
- addr_a  in  AW  requester A pixel address.
- data_a  in  24  requester A colour.
- ack_a  out  1  one-cycle pulse when A's write is performed.
- req_b, addr_b, data_b, ack_b: same as A, for requester B.
- commit  in  1  one-cycle pulse requesting a swap at the next frame boundary.
- clear  in  1  one-cycle pulse that zero-fills the back buffer.
- brightness  in  8  global scale; ignored unless BRIGHT_EN is defined.
- busy  out  1  high in COPY or FILL; no writes are granted.
- swap_pending  out  1  high while in PENDING.
- frame_done  out  1  one-cycle pulse in the swap cycle.

## Operation
- Storage: two NPIX×24 register arrays. front_sel selects the front array.
- color_out is a combinational read of front[pixel_idx], with zero register latency. The driver latches colour one cycle after its index changes, so the read must settle within that cycle.
- Frame boundary: a wrap cycle is any cycle where the previous-cycle pixel_idx equals NPIX-1 and the current pixel_idx equals 0. The previous-cycle index is held in a 1-register delay.
- FSM states:
  - IDLE:
    - Writes are arbitrated.
    - clear goes to FILL.
    - commit goes to PENDING.
    - If clear and commit arrive together, clear wins and commit is dropped.
  - PENDING:
    - Writes are arbitrated.
    - commit and clear are ignored.
    - On a wrap cycle: toggle front_sel, pulse frame_done, clear copy_cnt, go to COPY. No write is granted in that cycle.
  - COPY:
    - Each cycle, back[copy_cnt] ← front[copy_cnt] and copy_cnt increments.
    - After entry NPIX-1 is copied, return to IDLE, so COPY lasts exactly NPIX cycles.
    - commit and clear are ignored.
  - FILL:
    - Each cycle, back[cnt] ← 0, for NPIX cycles, then return to IDLE.
- Arbiter:
  - Runs only in IDLE or PENDING, excluding the wrap cycle.
  - At most one grant per cycle. The granted write sets back[addr] ← data, and the matching ack pulses in the same cycle.
  - If both requesters are asserted, grant the one not granted last. last_grant resets to B, so A wins the first tie.
  - Addresses ≥ NPIX are acked but not written.
  - A write and a commit in the same IDLE cycle are both honoured; the write is included in the swapped frame.
- Reset values:
  - All buffer entries 0, so color_out = 0.
  - front_sel = 0, state = IDLE, counters 0.
  - ack_a = ack_b = busy = swap_pending = frame_done = 0.
  - Reset asserted mid-COPY or mid-FILL aborts the operation and applies all reset values at the next edge.

## Timing
- Write: req sampled at edge N → ack high and array updated in cycle N. Requester deasserts or changes req after seeing ack.
- Writes stall during COPY/FILL: ack stays low and req must be held.
- Worst-case write latency = NPIX + 2 cycles, plus 1 cycle if losing a tie.
- Commit to swap: waits until the next wrap cycle.
- After a swap, busy is high for exactly NPIX cycles, then writes are granted again.
- COPY completes well inside the driver's reset gap, so the front buffer is never modified while the driver reads it.

## Configuration
- BRIGHT_EN defined:
  - Each 8-bit channel of color_out = (ch × (brightness+1)) >> 8.
  - The path is combinational, with one 8×9 multiply per channel.
  - brightness = 255 gives an identity output.
- BRIGHT_EN undefined:
  - color_out = raw front-buffer entry.
  - The brightness input is unused.

## Test plan
- Reset then idle: color_out = 0x000000 for every pixel_idx 0..63; all outputs are 0.
- Tie arbitration: A writes addr 5 = 0xFF0000 and B writes addr 9 = 0x00FF00, both asserted together → ack_a in the first cycle, ack_b in the next. After commit and wrap, the front shows both values.
- Commit and swap: commit while pixel_idx = 30 → swap_pending = 1, with no swap until the 63→0 transition. frame_done pulses in that cycle, then busy is high for 64 cycles and the back buffer equals the front.
- Stall: req_a asserted during COPY → ack_a stays low until COPY ends, then is granted in the first IDLE cycle.
- Clear: clear+commit in the same cycle → FILL runs for 64 cycles and swap_pending stays 0. A later commit+wrap shows all zeros.
- BRIGHT_EN: front entry 0x804020 with brightness 127 → color_out = 0x402010. With brightness 255 → 0x804020.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered NPIX-pixel frame store feeding the WS2812 strip driver.
// Optional macro BRIGHT_EN enables global brightness scaling of color_out.
module ws2812_frame_ctrl #(
  parameter int unsigned NPIX = 64,
  parameter int unsigned AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pixel_idx,
  output logic [23:0]   color_out,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [23:0]   data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [23:0]   data_b,
  output logic          ack_b,
  input  logic          commit,
  input  logic          clear,
  input  logic [7:0]    brightness,
  output logic          busy,
  output logic          swap_pending,
  output logic          frame_done
);

  localparam int unsigned CW = 24;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COPY    = 2'd2,
    S_FILL    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] mem0 [NPIX];
  logic [CW-1:0] mem1 [NPIX];
  logic          front_sel;
  logic [AW-1:0] cnt;
  logic [AW-1:0] prev_idx;
  logic          last_b;

  logic          wrap;
  logic          cnt_last;
  logic          grant_a, grant_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [CW-1:0] copy_src;
  logic [CW-1:0] front_raw;

  assign wrap     = (prev_idx == AW'(NPIX - 1)) && (pixel_idx == '0);
  assign cnt_last = (cnt == AW'(NPIX - 1));
  assign copy_src = front_sel ? mem1[cnt] : mem0[cnt];

  // Front-buffer lookup for the driver; out-of-range indices read as black.
  always_comb begin
    front_raw = '0;
    if (32'(pixel_idx) < NPIX)
      front_raw = front_sel ? mem1[pixel_idx] : mem0[pixel_idx];
  end

`ifdef BRIGHT_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
    logic [16:0] prod;
    prod = 17'(ch) * (17'(b) + 17'd1);
    return 8'(prod >> 8);
  endfunction

  assign color_out = {scale_ch(front_raw[23:16], brightness),
                      scale_ch(front_raw[15:8],  brightness),
                      scale_ch(front_raw[7:0],   brightness)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign color_out         = front_raw;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear outranks a simultaneous commit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear)       state_nxt = S_FILL;
        else if (commit) state_nxt = S_PENDING;
      end
      S_PENDING: if (wrap)     state_nxt = S_COPY;
      S_COPY:    if (cnt_last) state_nxt = S_IDLE;
      S_FILL:    if (cnt_last) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs and back-buffer write port; arbitration is blocked in the swap cycle.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    busy         = 1'b0;
    swap_pending = 1'b0;
    frame_done   = 1'b0;
    case (state)
      S_IDLE, S_PENDING: begin
        swap_pending = (state == S_PENDING);
        frame_done   = (state == S_PENDING) && wrap;
        if (!rst && !frame_done) begin
          grant_a = req_a && (!req_b || last_b);
          grant_b = req_b && (!req_a || !last_b);
        end
        if (grant_a) begin
          wr_en   = (32'(addr_a) < NPIX);
          wr_addr = addr_a;
          wr_data = data_a;
        end else if (grant_b) begin
          wr_en   = (32'(addr_b) < NPIX);
          wr_addr = addr_b;
          wr_data = data_b;
        end
      end
      S_COPY: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = copy_src;
      end
      S_FILL: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = cnt;
      end
      default: ;
    endcase
  end

  assign ack_a = grant_a;
  assign ack_b = grant_b;

  // Control registers: counter, buffer select, arbiter history, index delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      front_sel <= 1'b0;
      last_b    <= 1'b1;
      prev_idx  <= '0;
    end else begin
      prev_idx <= pixel_idx;
      if (frame_done)                    front_sel <= ~front_sel;
      if (grant_a)                       last_b    <= 1'b0;
      else if (grant_b)                  last_b    <= 1'b1;
      if (frame_done || (state == S_IDLE && clear)) cnt <= '0;
      else if (busy)                     cnt <= cnt + AW'(1);
    end
  end

  // Buffer arrays; only the back buffer is ever written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NPIX); i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel) mem0[wr_addr] <= wr_data;
      else           mem1[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed self-checking bench for ws2812_frame_ctrl.
module tb_ws2812_frame_ctrl;

  localparam int unsigned NPIX = 64;
  localparam int unsigned AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pixel_idx;
  logic [23:0]   color_out;
  logic          req_a, req_b, ack_a, ack_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [23:0]   data_a, data_b;
  logic          commit, clear;
  logic [7:0]    brightness;
  logic          busy, swap_pending, frame_done;

  int total = 0;
  int bad   = 0;
  int stall_acks;
  int n;
  int cnt_bad;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(.NPIX(NPIX), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pixel_idx(pixel_idx), .color_out(color_out),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .commit(commit), .clear(clear), .brightness(brightness),
    .busy(busy), .swap_pending(swap_pending), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, plus any acks seen while busy.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (ack_a || ack_b) stall_acks++;
      tick();
    end
    #1;
    if (cycles >= 200) check("busy_timeout", 32'(cycles), 32'(NPIX));
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [23:0] d);
    int k;
    req_a = 1'b1; addr_a = a; data_a = d;
    #1;
    k = 0;
    while (!ack_a && k < 200) begin k++; tick(); end
    if (k >= 200) check("write_timeout", 32'(k), 32'd0);
    tick();
    req_a = 1'b0;
  endtask

  // Commit at index 63, wrap to 0 next cycle, then let COPY finish.
  task automatic do_swap;
    int c;
    pixel_idx = 6'd63; commit = 1'b1;
    tick();
    commit = 1'b0; pixel_idx = 6'd0;
    #1;
    check("swap_frame_done", 32'(frame_done), 32'd1);
    tick();
    wait_busy(c);
    check("swap_busy_len", 32'(c), 32'(NPIX));
  endtask

  initial begin
    rst = 1'b1; pixel_idx = '0;
    req_a = 1'b0; addr_a = '0; data_a = '0;
    req_b = 1'b0; addr_b = '0; data_b = '0;
    commit = 1'b0; clear = 1'b0; brightness = 8'd255;
    stall_acks = 0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state: all outputs low, front buffer black.
    check("rst_ack_a", 32'(ack_a), 32'd0);
    check("rst_ack_b", 32'(ack_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    cnt_bad = 0;
    for (int i = 0; i < int'(NPIX); i++) begin
      pixel_idx = AW'(i);
      #1;
      if (color_out !== 24'h0) cnt_bad++;
    end
    check("rst_color_all", 32'(cnt_bad), 32'd0);
    tick();

    // Tie: A wins first, B next cycle.
    pixel_idx = 6'd10;
    req_a = 1'b1; addr_a = 6'd5; data_a = 24'hFF0000;
    req_b = 1'b1; addr_b = 6'd9; data_b = 24'h00FF00;
    #1;
    check("tie_ack_a_first", 32'(ack_a), 32'd1);
    check("tie_ack_b_first", 32'(ack_b), 32'd0);
    tick();
    req_a = 1'b0;
    #1;
    check("tie_ack_a_second", 32'(ack_a), 32'd0);
    check("tie_ack_b_second", 32'(ack_b), 32'd1);
    tick();
    req_b = 1'b0;
    pixel_idx = 6'd5;
    #1;
    check("back_not_visible", 32'(color_out), 32'h0);

    // Commit at index 30; swap only on the 63->0 transition.
    tick();
    pixel_idx = 6'd30; commit = 1'b1;
    tick();
    commit = 1'b0;
    cnt_bad = 0;
    for (int i = 31; i < int'(NPIX); i++) begin
      pixel_idx = AW'(i);
      #1;
      if (!swap_pending || frame_done || busy) cnt_bad++;
      tick();
    end
    check("pending_hold", 32'(cnt_bad), 32'd0);
    pixel_idx = 6'd0;
    req_a = 1'b1; addr_a = 6'd7; data_a = 24'h123456;
    #1;
    check("wrap_frame_done", 32'(frame_done), 32'd1);
    check("wrap_no_grant", 32'(ack_a), 32'd0);
    tick();
    check("copy_busy", 32'(busy), 32'd1);
    check("copy_no_pending", 32'(swap_pending), 32'd0);
    check("copy_no_frame_done", 32'(frame_done), 32'd0);
    stall_acks = 0;
    wait_busy(n);
    check("copy_len", 32'(n), 32'd64);
    check("stall_no_ack", 32'(stall_acks), 32'd0);
    check("stall_grant_after", 32'(ack_a), 32'd1);
    tick();
    req_a = 1'b0;
    pixel_idx = 6'd5; #1;
    check("front_px5", 32'(color_out), 32'hFF0000);
    pixel_idx = 6'd9; #1;
    check("front_px9", 32'(color_out), 32'h00FF00);
    pixel_idx = 6'd7; #1;
    check("front_px7_pre", 32'(color_out), 32'h0);

    // Second swap exposes the copied back buffer plus the stalled write.
    tick();
    do_swap();
    pixel_idx = 6'd5; #1;
    check("copy_px5", 32'(color_out), 32'hFF0000);
    pixel_idx = 6'd9; #1;
    check("copy_px9", 32'(color_out), 32'h00FF00);
    pixel_idx = 6'd7; #1;
    check("copy_px7", 32'(color_out), 32'h123456);

    // Clear + commit together: clear wins, commit dropped.
    tick();
    clear = 1'b1; commit = 1'b1;
    tick();
    clear = 1'b0; commit = 1'b0;
    #1;
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_no_pending", 32'(swap_pending), 32'd0);
    wait_busy(n);
    check("fill_len", 32'(n), 32'd64);
    check("fill_after_pending", 32'(swap_pending), 32'd0);
    pixel_idx = 6'd5; #1;
    check("fill_front_kept", 32'(color_out), 32'hFF0000);
    tick();
    do_swap();
    pixel_idx = 6'd5; #1;
    check("clr_px5", 32'(color_out), 32'h0);
    pixel_idx = 6'd7; #1;
    check("clr_px7", 32'(color_out), 32'h0);
    pixel_idx = 6'd9; #1;
    check("clr_px9", 32'(color_out), 32'h0);

    // Brightness path.
    tick();
    write_a(6'd3, 24'h804020);
    do_swap();
    pixel_idx = 6'd3; brightness = 8'd127; #1;
`ifdef BRIGHT_EN
    check("bright_127", 32'(color_out), 32'h402010);
`else
    check("bright_ignored", 32'(color_out), 32'h804020);
`endif
    brightness = 8'd255; #1;
    check("bright_255", 32'(color_out), 32'h804020);

    // Reset in the middle of COPY aborts and clears everything.
    tick();
    pixel_idx = 6'd63; commit = 1'b1;
    tick();
    commit = 1'b0; pixel_idx = 6'd0;
    tick(); tick(); tick(); tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pixel_idx = 6'd3;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pending", 32'(swap_pending), 32'd0);
    check("abort_color", 32'(color_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
